ad_sample_buf: RTL and testbench
================================

AD_SAMPLE_BUF -- requirements
Module: ad_sample_buf

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the ADC sample width in bits.
REQ-002 SHALL have parameter FIFO_AW, default 11, meaning the log2 of the FIFO depth (2048 words).
REQ-003 SHALL have parameter FRAME_WORDS, default 512, meaning the number of words that must be buffered before one read_req is granted.
REQ-004 SHALL have port clk, input, 1 bit: single clock, shared with the Ethernet tx domain.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port ad_data, input, DW bits: converted sample from the ADC interface.
REQ-007 SHALL have port ad_data_valid, input, 1 bit: ad_data is valid this cycle (one-cycle strobe).
REQ-008 SHALL have port ad_sample_req, input, 1 bit: level request to capture sample_len words.
REQ-009 SHALL have port sample_len, input, 32 bits: number of words to capture, sampled at start.
REQ-010 SHALL have port ad_sample_ack, output, 1 bit: one-cycle pulse when the capture completes.
REQ-011 SHALL have port read_req, input, 1 bit: level request from the MAC controller to send one frame.
REQ-012 SHALL have port read_req_ack, output, 1 bit: one-cycle grant of read_req.
REQ-013 SHALL have port fifo_rd_en, input, 1 bit: pops one word.
REQ-014 SHALL have port fifo_data, output, DW bits: read data.
REQ-015 SHALL have port fifo_data_count, output, 12 bits: number of words stored.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped because the FIFO is full.

Function
REQ-017 FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-018 IDLE->CAPTURE: ad_sample_req=1 and sample_len!=0; SHALL latch sample_len into a 32-bit down-counter, flush the FIFO (count=0 next cycle) and clear overflow.
REQ-019 IDLE with ad_sample_req=1 and sample_len==0: SHALL pulse ad_sample_ack the next cycle, write nothing, and go to DONE.
REQ-020 CAPTURE: each ad_data_valid while not full SHALL write ad_data and decrement the counter; ad_data_valid while full SHALL drop the word, set overflow and still decrement the counter.
REQ-021 CAPTURE->DONE: on the cycle the counter reaches 0, ad_sample_ack SHALL be 1 for exactly that next cycle; ad_data_valid SHALL be ignored outside CAPTURE.
REQ-022 DONE->IDLE: ad_sample_req=0; while req stays 1, DONE SHALL hold and SHALL NOT restart.
REQ-023 ad_sample_req falling in CAPTURE SHALL abort to IDLE with no ack, and FIFO contents SHALL be kept.
REQ-024 FIFO SHALL be synchronous; fifo_data SHALL be valid 1 cycle after fifo_rd_en; fifo_rd_en when empty SHALL be ignored (data holds, count stays 0).
REQ-025 Simultaneous write and read SHALL leave the count unchanged; the count SHALL be exact and range 0..2048; pointers SHALL wrap modulo 2^FIFO_AW.
REQ-026 read_req_ack SHALL pulse 1 cycle when read_req=1, no grant is outstanding, and either fifo_data_count>=FRAME_WORDS, or state!=CAPTURE and fifo_data_count>0.
REQ-027 After a grant, no further ack SHALL be issued until read_req has been seen at 0.

Reset
REQ-028 On rst=1: state SHALL be IDLE, the FIFO SHALL be empty, and the counter SHALL be 0.
REQ-029 On rst=1, outputs SHALL be ad_sample_ack=0, read_req_ack=0, overflow=0, fifo_data=0 and fifo_data_count=0.
REQ-030 rst mid-capture SHALL discard all data; the next request SHALL start cleanly.

Structure
REQ-031 The shared package SHALL hold the state enum, DW, FIFO_AW, FRAME_WORDS defaults and the count width 12.
REQ-032 There SHALL be one sub-module, sync_fifo (depth 2^FIFO_AW, width DW, registered output, count output).

Verification
REQ-033 Scenario: sample_len=4, samples 0x0001..0x0004 on valid strobes -> ad_sample_ack 1 cycle after the 4th strobe; count=4; four reads return 0x0001..0x0004 in order.
REQ-034 Scenario: sample_len=0 -> ack next cycle, count stays 0, no read_req_ack.
REQ-035 Scenario: sample_len=3000 with no reads -> count saturates at 2048, overflow=1, ack still after the 3000th strobe.
REQ-036 Scenario: read_req held with count=511 during CAPTURE -> no ack; the 512th write -> read_req_ack on the next cycle, a single pulse until read_req drops.
REQ-037 Scenario: read and write on the same cycle at count=2048 -> write dropped, overflow set; at count=0 a read is ignored.
REQ-038 Scenario: rst asserted after 100 of 200 samples -> all outputs 0 next cycle; a new request for 5 samples returns only the new data.

Source files
------------

// File: rtl/ad_sample_buf_pkg.sv
// Shared definitions for the ADC sample buffer: parameter defaults, widths
// and FSM state encodings.
package ad_sample_buf_pkg;

  localparam int unsigned DW_DEF          = 16;
  localparam int unsigned FIFO_AW_DEF     = 11;
  localparam int unsigned FRAME_WORDS_DEF = 512;
  localparam int unsigned CNT_W           = 12;
  localparam int unsigned LEN_W           = 32;

  // Capture FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CAPTURE = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/ad_sample_buf_sync_fifo.sv
// Single-clock FIFO with registered read data and an exact occupancy count.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : empties the FIFO (pointers and count to zero)
//   wr_en, wr_data    : push; ignored while full
//   rd_en, rd_data    : pop; rd_data is valid the cycle after rd_en, holds when empty
//   count             : words stored, 0..2^AW
//   full_c, empty_c   : combinational status decoded from count
module sync_fifo #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign wr_ok   = wr_en && !full_c && !flush;
  assign rd_ok   = rd_en && !empty_c && !flush;

  // Storage array, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at 2^AW; count tracks the exact occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ad_sample_buf.sv
// ADC sample capture buffer: captures sample_len words into a FIFO on
// request and grants frame reads to the MAC controller once enough data
// is buffered.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ad_data, ad_data_valid       : sample stream from the ADC interface
//   ad_sample_req, sample_len    : level capture request and its length
//   ad_sample_ack                : one-cycle pulse when capture completes
//   read_req, read_req_ack       : frame read request and its one-cycle grant
//   fifo_rd_en, fifo_data        : FIFO pop and registered read data
//   fifo_data_count              : words stored
//   overflow                     : sticky, a sample was dropped on a full FIFO
module ad_sample_buf
  import ad_sample_buf_pkg::*;
#(
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned FIFO_AW     = FIFO_AW_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    ad_data,
  input  logic             ad_data_valid,
  input  logic             ad_sample_req,
  input  logic [LEN_W-1:0] sample_len,
  output logic             ad_sample_ack,
  input  logic             read_req,
  output logic             read_req_ack,
  input  logic             fifo_rd_en,
  output logic [DW-1:0]    fifo_data,
  output logic [CNT_W-1:0] fifo_data_count,
  output logic             overflow
);

  localparam int unsigned CW = FIFO_AW + 1;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remain;
  logic             granted;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full_c;
  logic             fifo_empty_c;

  logic             flush_c;
  logic             wr_c;
  logic             drop_c;
  logic             dec_c;
  logic             ack_c;
  logic             grant_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle capture controls
  always_comb begin
    state_nxt = state;
    flush_c   = 1'b0;
    wr_c      = 1'b0;
    drop_c    = 1'b0;
    dec_c     = 1'b0;
    ack_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ad_sample_req) begin
          if (sample_len != '0) begin
            flush_c   = 1'b1;
            state_nxt = ST_CAPTURE;
          end else begin
            ack_c     = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_CAPTURE: begin
        // Dropping the request aborts; buffered words stay in the FIFO
        if (!ad_sample_req) begin
          state_nxt = ST_IDLE;
        end else if (ad_data_valid) begin
          dec_c  = 1'b1;
          wr_c   = !fifo_full_c;
          drop_c = fifo_full_c;
          if (remain == LEN_W'(1)) begin
            ack_c     = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!ad_sample_req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Remaining-word counter, completion pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      remain        <= '0;
      ad_sample_ack <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      ad_sample_ack <= ack_c;
      if (flush_c) begin
        remain   <= sample_len;
        overflow <= 1'b0;
      end else begin
        if (dec_c) begin
          remain <= remain - LEN_W'(1);
        end
        if (drop_c) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Grant a frame once a full frame is buffered, or any data once capture is not running
  assign grant_c = read_req && !granted &&
                   ((fifo_cnt >= CW'(FRAME_WORDS)) ||
                    ((state != ST_CAPTURE) && !fifo_empty_c));

  // One grant per read_req assertion; re-armed when read_req is seen low
  always_ff @(posedge clk) begin
    if (rst) begin
      read_req_ack <= 1'b0;
      granted      <= 1'b0;
    end else begin
      read_req_ack <= grant_c;
      granted      <= read_req && (granted || grant_c);
    end
  end

  sync_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_c),
    .wr_en   (wr_c),
    .wr_data (ad_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_data),
    .count   (fifo_cnt),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign fifo_data_count = CNT_W'(fifo_cnt);

endmodule

// File: tb/tb_ad_sample_buf.sv
// Directed bench for ad_sample_buf: capture, zero-length request, frame
// grant threshold, overflow at full, empty read and mid-capture reset.
module tb_ad_sample_buf;

  logic        clk;
  logic        rst;
  logic [15:0] ad_data;
  logic        ad_data_valid;
  logic        ad_sample_req;
  logic [31:0] sample_len;
  logic        ad_sample_ack;
  logic        read_req;
  logic        read_req_ack;
  logic        fifo_rd_en;
  logic [15:0] fifo_data;
  logic [11:0] fifo_data_count;
  logic        overflow;

  int checks;
  int failures;
  int seen;

  ad_sample_buf dut (
    .clk             (clk),
    .rst             (rst),
    .ad_data         (ad_data),
    .ad_data_valid   (ad_data_valid),
    .ad_sample_req   (ad_sample_req),
    .sample_len      (sample_len),
    .ad_sample_ack   (ad_sample_ack),
    .read_req        (read_req),
    .read_req_ack    (read_req_ack),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_data       (fifo_data),
    .fifo_data_count (fifo_data_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ad_data = '0;
    ad_data_valid = 1'b0;
    ad_sample_req = 1'b0;
    sample_len = '0;
    read_req = 1'b0;
    fifo_rd_en = 1'b0;
    tick();
    tick();
    chk("rst_ack", 32'(ad_sample_ack), 32'd0);
    chk("rst_rra", 32'(read_req_ack), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_count", 32'(fifo_data_count), 32'd0);
    rst = 1'b0;
    tick();

    // Capture four samples
    ad_sample_req = 1'b1;
    sample_len = 32'd4;
    tick();
    for (int i = 1; i <= 4; i++) begin
      ad_data = 16'(i);
      ad_data_valid = 1'b1;
      tick();
    end
    chk("cap4_ack", 32'(ad_sample_ack), 32'd1);
    chk("cap4_count", 32'(fifo_data_count), 32'd4);
    // DONE holds while the request stays high; strobes are ignored
    ad_data = 16'h0009;
    tick();
    chk("cap4_ack_pulse", 32'(ad_sample_ack), 32'd0);
    tick();
    ad_data_valid = 1'b0;
    chk("done_hold_count", 32'(fifo_data_count), 32'd4);
    chk("done_hold_ack", 32'(ad_sample_ack), 32'd0);
    ad_sample_req = 1'b0;
    tick();
    fifo_rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("cap4_rd%0d", i), 32'(fifo_data), 32'(i));
    end
    chk("cap4_empty", 32'(fifo_data_count), 32'd0);
    tick();
    fifo_rd_en = 1'b0;
    chk("empty_rd_data", 32'(fifo_data), 32'd4);
    chk("empty_rd_count", 32'(fifo_data_count), 32'd0);

    // Zero-length request
    ad_sample_req = 1'b1;
    sample_len = 32'd0;
    read_req = 1'b1;
    tick();
    chk("len0_ack", 32'(ad_sample_ack), 32'd1);
    chk("len0_count", 32'(fifo_data_count), 32'd0);
    chk("len0_rra", 32'(read_req_ack), 32'd0);
    tick();
    chk("len0_ack_pulse", 32'(ad_sample_ack), 32'd0);
    chk("len0_rra2", 32'(read_req_ack), 32'd0);
    ad_sample_req = 1'b0;
    read_req = 1'b0;
    tick();

    // Frame grant threshold during capture
    ad_sample_req = 1'b1;
    sample_len = 32'd600;
    tick();
    read_req = 1'b1;
    seen = 0;
    for (int i = 1; i <= 511; i++) begin
      ad_data = 16'(i);
      ad_data_valid = 1'b1;
      tick();
      if (read_req_ack) seen++;
    end
    chk("thr_count511", 32'(fifo_data_count), 32'd511);
    chk("thr_no_grant", 32'(seen), 32'd0);
    ad_data = 16'd512;
    tick();
    ad_data_valid = 1'b0;
    chk("thr_count512", 32'(fifo_data_count), 32'd512);
    chk("thr_rra_wait", 32'(read_req_ack), 32'd0);
    tick();
    chk("thr_rra", 32'(read_req_ack), 32'd1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (read_req_ack) seen++;
    end
    chk("thr_single_pulse", 32'(seen), 32'd0);
    read_req = 1'b0;
    tick();
    read_req = 1'b1;
    tick();
    chk("thr_regrant", 32'(read_req_ack), 32'd1);
    // Abort keeps the buffered words and gives no ack
    read_req = 1'b0;
    ad_sample_req = 1'b0;
    tick();
    chk("abort_ack", 32'(ad_sample_ack), 32'd0);
    tick();
    chk("abort_ack2", 32'(ad_sample_ack), 32'd0);
    chk("abort_count", 32'(fifo_data_count), 32'd512);

    // Overflow: 3000 samples into a 2048-word FIFO
    ad_sample_req = 1'b1;
    sample_len = 32'd3000;
    tick();
    chk("ovf_flush", 32'(fifo_data_count), 32'd0);
    for (int i = 1; i <= 2048; i++) begin
      ad_data = 16'(i);
      ad_data_valid = 1'b1;
      tick();
    end
    chk("ovf_full", 32'(fifo_data_count), 32'd2048);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    // Simultaneous read and write at full: the write is dropped
    ad_data = 16'd2049;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("ovf_rw_count", 32'(fifo_data_count), 32'd2047);
    chk("ovf_rw_flag", 32'(overflow), 32'd1);
    chk("ovf_rw_data", 32'(fifo_data), 32'd1);
    seen = 0;
    for (int i = 2050; i <= 3000; i++) begin
      if (ad_sample_ack) seen++;
      ad_data = 16'(i);
      tick();
    end
    ad_data_valid = 1'b0;
    chk("ovf_early_ack", 32'(seen), 32'd0);
    chk("ovf_ack", 32'(ad_sample_ack), 32'd1);
    chk("ovf_count", 32'(fifo_data_count), 32'd2048);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    tick();
    chk("ovf_ack_pulse", 32'(ad_sample_ack), 32'd0);
    ad_sample_req = 1'b0;
    tick();

    // Reset mid-capture, then a clean five-sample capture
    ad_sample_req = 1'b1;
    sample_len = 32'd200;
    tick();
    chk("rst2_ovf_clear", 32'(overflow), 32'd0);
    chk("rst2_flush", 32'(fifo_data_count), 32'd0);
    for (int i = 0; i < 100; i++) begin
      ad_data = 16'(16'hA000 + i);
      ad_data_valid = 1'b1;
      tick();
    end
    chk("rst2_count100", 32'(fifo_data_count), 32'd100);
    rst = 1'b1;
    ad_data_valid = 1'b0;
    ad_sample_req = 1'b0;
    tick();
    chk("rst2_ack", 32'(ad_sample_ack), 32'd0);
    chk("rst2_rra", 32'(read_req_ack), 32'd0);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    chk("rst2_data", 32'(fifo_data), 32'd0);
    chk("rst2_count", 32'(fifo_data_count), 32'd0);
    rst = 1'b0;
    tick();
    ad_sample_req = 1'b1;
    sample_len = 32'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      ad_data = 16'(16'h5000 + i);
      ad_data_valid = 1'b1;
      tick();
    end
    ad_data_valid = 1'b0;
    chk("new5_ack", 32'(ad_sample_ack), 32'd1);
    chk("new5_count", 32'(fifo_data_count), 32'd5);
    ad_sample_req = 1'b0;
    tick();
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("new5_rd%0d", i), 32'(fifo_data), 32'(16'h5000 + i));
    end
    fifo_rd_en = 1'b0;
    tick();
    chk("new5_empty", 32'(fifo_data_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
